// File: rtl/mod_arith_pkg.sv
// Shared constants and types for the modular arithmetic units.
// Serves mod_sub_pipe and mod_add.
package mod_arith_pkg;

  localparam int Q_WIDTH = 23;
  localparam int unsigned DILITHIUM_Q = 32'd8380417;

  // difference a - b with its borrow in the MSB
  typedef logic [Q_WIDTH:0] mod_diff_t;

endpackage

// File: rtl/pipe_stage.sv
// Generic valid/ready register slice with a data-width parameter.
// Ports: clk_i, rst_n_i, in_* (upstream side), out_* (downstream side).
module pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  // load when empty or when the held item leaves this cycle
  assign in_ready  = !valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid)
        data_q <= in_data;
    end
  end

endmodule

// File: rtl/mod_sub_pipe.sv
// Two-stage modular subtractor: c = (a - b) mod q, valid/ready on both sides.
// Ports: clk_i, rst_n_i, valid_i/ready_o/a_i/b_i/q_i in, valid_o/ready_i/c_o out.
module mod_sub_pipe
  import mod_arith_pkg::*;
#(
  parameter int W = Q_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] q_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] c_o
);

  localparam int S1W = 2 * W + 1;

  logic [W:0]     d;
  logic [S1W-1:0] s1_in;
  logic [S1W-1:0] s1_out;
  logic           s1_valid;
  logic           s2_ready;
  logic [W:0]     s1_d;
  logic [W-1:0]   s1_q;
  logic [W-1:0]   c_next;

  assign d     = {1'b0, a_i} - {1'b0, b_i};
  assign s1_in = {d, q_i};

  pipe_stage #(.DW(S1W)) u_s1 (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .in_valid (valid_i),
    .in_ready (ready_o),
    .in_data  (s1_in),
    .out_valid(s1_valid),
    .out_ready(s2_ready),
    .out_data (s1_out)
  );

  assign s1_d = s1_out[S1W-1:W];
  assign s1_q = s1_out[W-1:0];

  // borrow set means a < b: fold back by adding the carried q
  assign c_next = s1_d[W] ? s1_d[W-1:0] + s1_q : s1_d[W-1:0];

  pipe_stage #(.DW(W)) u_s2 (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .in_valid (s1_valid),
    .in_ready (s2_ready),
    .in_data  (c_next),
    .out_valid(valid_o),
    .out_ready(ready_i),
    .out_data (c_o)
  );

endmodule

// File: tb/tb_mod_sub_pipe.sv
// Self-checking bench for mod_sub_pipe.
// Directed scenarios plus a random throughput run.
module tb_mod_sub_pipe;

  localparam int W = 23;
  localparam logic [W-1:0] DQ = 23'd8380417;

  logic         clk_i;
  logic         rst_n_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [W-1:0] q_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] c_o;

  int n_assert;
  int n_fail;

  mod_sub_pipe #(.W(W)) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .a_i    (a_i),
    .b_i    (b_i),
    .q_i    (q_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .c_o    (c_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  // single triple through an idle pipe, checking latency exactly
  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] exp,
                         input string name);
    valid_i = 1'b1;
    a_i = a;
    b_i = b;
    q_i = q;
    ready_i = 1'b1;
    #1;
    n_assert++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_o: got %b want 1", name, ready_o);
    end
    step();
    valid_i = 1'b0;
    n_assert++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s early valid_o: got %b want 0", name, valid_o);
    end
    step();
    n_assert++;
    if (valid_o !== 1'b1 || c_o !== exp) begin
      n_fail++;
      $display("FAIL %s result: got v=%b c=%0d want v=1 c=%0d",
               name, valid_o, c_o, exp);
    end
    step();
    n_assert++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s drain valid_o: got %b want 0", name, valid_o);
    end
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    a_i = '0;
    b_i = '0;
    q_i = '0;
    #1;
    n_assert++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || c_o !== '0) begin
      n_fail++;
      $display("FAIL reset: got v=%b r=%b c=%0d want v=0 r=1 c=0",
               valid_o, ready_o, c_o);
    end
    #12;
    rst_n_i = 1'b1;
  endtask

  task automatic test_basic;
    run_one(23'd20, 23'd3, 23'd40, 23'd17, "basic");
  endtask

  task automatic test_wrap;
    run_one(23'd3, 23'd20, 23'd40, 23'd23, "wrap_3_20");
    run_one(23'd0, 23'd39, 23'd40, 23'd1, "wrap_0_39");
    run_one(23'd39, 23'd39, 23'd40, 23'd0, "equal");
    run_one(23'd0, 23'd1, DQ, 23'd8380416, "wrap_dq");
  endtask

  task automatic test_backpressure;
    logic [W-1:0] av[4];
    logic [W-1:0] bv[4];
    logic [W-1:0] ev[4];
    int in_i;
    int out_i;
    logic prev_stall;
    logic [W-1:0] prev_c;
    av = '{23'd5, 23'd1, 23'd7, 23'd0};
    bv = '{23'd1, 23'd5, 23'd7, 23'd1};
    ev = '{23'd4, 23'd36, 23'd0, 23'd39};
    in_i = 0;
    out_i = 0;
    prev_stall = 1'b0;
    prev_c = '0;
    q_i = 23'd40;
    for (int t = 0; t < 30 && out_i < 4; t++) begin
      ready_i = !(t >= 1 && t <= 3);
      valid_i = (in_i < 4);
      if (in_i < 4) begin
        a_i = av[in_i];
        b_i = bv[in_i];
      end
      #1;
      if (t == 2) begin
        n_assert++;
        if (ready_o !== 1'b0 || in_i != 2) begin
          n_fail++;
          $display("FAIL bp_ready_drop: got r=%b held=%0d want r=0 held=2",
                   ready_o, in_i);
        end
      end
      if (prev_stall) begin
        n_assert++;
        if (valid_o !== 1'b1 || c_o !== prev_c) begin
          n_fail++;
          $display("FAIL bp_stable: got v=%b c=%0d want v=1 c=%0d",
                   valid_o, c_o, prev_c);
        end
      end
      if (valid_o && ready_i && out_i < 4) begin
        n_assert++;
        if (c_o !== ev[out_i]) begin
          n_fail++;
          $display("FAIL bp_result[%0d]: got %0d want %0d",
                   out_i, c_o, ev[out_i]);
        end
        out_i++;
      end
      if (valid_i && ready_o)
        in_i++;
      prev_stall = valid_o && !ready_i;
      prev_c = c_o;
      step();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    n_assert++;
    if (out_i != 4 || in_i != 4) begin
      n_fail++;
      $display("FAIL bp_count: got in=%0d out=%0d want 4/4", in_i, out_i);
    end
  endtask

  task automatic test_q_change;
    logic [W-1:0] qv[2];
    logic [W-1:0] ev[2];
    int out_i;
    qv = '{23'd40, 23'd30};
    ev = '{23'd23, 23'd13};
    out_i = 0;
    ready_i = 1'b1;
    a_i = 23'd3;
    b_i = 23'd20;
    for (int t = 0; t < 6; t++) begin
      valid_i = (t < 2);
      q_i = (t < 2) ? qv[t] : 23'd7;
      #1;
      if (valid_o) begin
        n_assert++;
        if (out_i > 1 || c_o !== ev[out_i] || t != out_i + 2) begin
          n_fail++;
          $display("FAIL qchg[%0d]: got c=%0d t=%0d want c=%0d t=%0d",
                   out_i, c_o, t, (out_i > 1) ? 0 : ev[out_i], out_i + 2);
        end
        out_i++;
      end
      step();
    end
    valid_i = 1'b0;
    n_assert++;
    if (out_i != 2) begin
      n_fail++;
      $display("FAIL qchg_count: got %0d want 2", out_i);
    end
  endtask

  task automatic test_reset_mid;
    ready_i = 1'b1;
    valid_i = 1'b1;
    a_i = 23'd9;
    b_i = 23'd2;
    q_i = 23'd40;
    step();
    a_i = 23'd5;
    b_i = 23'd1;
    step();
    valid_i = 1'b0;
    #1;
    n_assert++;
    if (valid_o !== 1'b1 || c_o !== 23'd7) begin
      n_fail++;
      $display("FAIL rst_pre: got v=%b c=%0d want v=1 c=7", valid_o, c_o);
    end
    #1;
    rst_n_i = 1'b0;
    #1;
    n_assert++;
    if (valid_o !== 1'b0 || c_o !== '0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async: got v=%b c=%0d r=%b want v=0 c=0 r=1",
               valid_o, c_o, ready_o);
    end
    #10;
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_assert++;
      if (valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_stale[%0d]: got v=%b c=%0d want v=0",
                 i, valid_o, c_o);
      end
    end
    run_one(23'd20, 23'd3, 23'd40, 23'd17, "rst_after");
  endtask

  task automatic test_throughput;
    logic [W-1:0] av[100];
    logic [W-1:0] bv[100];
    logic [W-1:0] ev[100];
    int in_i;
    int out_i;
    int last_t;
    for (int i = 0; i < 100; i++) begin
      av[i] = W'($urandom_range(32'(DQ) - 1, 0));
      bv[i] = W'($urandom_range(32'(DQ) - 1, 0));
      ev[i] = (av[i] >= bv[i]) ? av[i] - bv[i] : W'(av[i] + DQ - bv[i]);
    end
    in_i = 0;
    out_i = 0;
    last_t = -1;
    ready_i = 1'b1;
    q_i = DQ;
    for (int t = 0; t < 150 && out_i < 100; t++) begin
      valid_i = (in_i < 100);
      if (in_i < 100) begin
        a_i = av[in_i];
        b_i = bv[in_i];
      end
      #1;
      if (valid_o && out_i < 100) begin
        n_assert++;
        if (c_o !== ev[out_i]) begin
          n_fail++;
          $display("FAIL tput[%0d]: got %0d want %0d", out_i, c_o, ev[out_i]);
        end
        out_i++;
        last_t = t;
      end
      if (valid_i && ready_o)
        in_i++;
      step();
    end
    valid_i = 1'b0;
    n_assert++;
    if (out_i != 100 || last_t != 101) begin
      n_fail++;
      $display("FAIL tput_rate: got n=%0d last=%0d want n=100 last=101",
               out_i, last_t);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_q_change();
    test_reset_mid();
    test_throughput();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
